// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ball_engine
//  Purpose  : Single-paddle ball game engine: motion ticks, reflections,
//             paddle hits, misses, scoring and serve sequencing.
//  Revision : 1.0  initial release
// ============================================================================
module ball_engine #(
   parameter int BALL_SIZE      = 5,
   parameter int PADDLE_BREADTH = 5,
   parameter int PADDLE_LENGTH  = 15,
   parameter int PADDLE_X       = 220,
   parameter int WALL_X         = 3,
   parameter int Y_TOP          = 0,
   parameter int Y_BOTTOM       = 165,
   parameter int SERVE_X        = 120,
   parameter int SERVE_Y        = 80,
   parameter int TICK_DIV       = 500000,
   parameter int SERVE_TICKS    = 30,
   parameter int WIN_SCORE      = 10
) (
   input  logic       clock,
   input  logic       resetApp,
   input  logic       resetGame,
   input  logic       enableGame,
   input  logic [8:0] paddle_y,
   output logic [7:0] ball_x,
   output logic [8:0] ball_y,
   output logic [7:0] score,
   output logic [7:0] missCount,
   output logic       tickStrobe
);

   localparam int c_TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
   localparam logic [c_SERVE_W-1:0] c_SERVE_LAST = c_SERVE_W'(SERVE_TICKS - 1);
   localparam logic [9:0] c_WALL_LIM = 10'(WALL_X + BALL_SIZE);
   localparam logic [9:0] c_TOP_LIM  = 10'(Y_TOP + BALL_SIZE);
   localparam logic [9:0] c_BOTTOM   = 10'(Y_BOTTOM);
   localparam logic [9:0] c_BALL     = 10'(BALL_SIZE);
   localparam logic [9:0] c_CONTACT  = 10'(BALL_SIZE + PADDLE_BREADTH);
   localparam logic [9:0] c_PADDLE_X = 10'(PADDLE_X);
   localparam logic [9:0] c_REACH    = 10'(PADDLE_LENGTH + BALL_SIZE);
   localparam logic [9:0] c_MISS_X   = 10'd239;
   localparam logic [7:0] c_SERVE_X  = 8'(SERVE_X);
   localparam logic [8:0] c_SERVE_Y  = 9'(SERVE_Y);
   localparam logic [7:0] c_WIN      = 8'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_MOVE  = 3'd2,
      S_MISS  = 3'd3,
      S_WON   = 3'd4
   } state_t;

   state_t                r_state;
   logic [c_TICK_W-1:0]   r_tickCount;
   logic [c_SERVE_W-1:0]  r_serveCount;
   logic                  r_dirRight;
   logic                  r_dirDown;

   logic                  w_tick;
   logic [c_TICK_W-1:0]   w_tickCountNext;
   logic [9:0]            w_x10, w_y10, w_p10;
   logic                  w_miss, w_hit;
   logic [7:0]            w_nextX;
   logic [8:0]            w_nextY;
   logic                  w_nextRight, w_nextDown;
   logic [7:0]            w_scoreInc;

   assign w_tick     = enableGame && (r_tickCount == c_TICK_LAST);
   assign w_x10      = {2'b00, ball_x};
   assign w_y10      = {1'b0, ball_y};
   assign w_p10      = {1'b0, paddle_y};
   assign w_scoreInc = score + 8'd1;

   // Constants sit on the opposite side of every comparison so nothing underflows.
   assign w_miss = r_dirRight && (w_x10 + c_BALL >= c_MISS_X);
   assign w_hit  = r_dirRight && (w_x10 + c_CONTACT == c_PADDLE_X)
                   && (w_y10 + c_REACH >= w_p10) && (w_p10 + c_REACH >= w_y10);

   always_comb begin
      w_tickCountNext = r_tickCount;
      if (enableGame) begin
         w_tickCountNext = w_tick ? '0 : r_tickCount + 1'b1;
      end
   end

   always_comb begin
      w_nextRight = r_dirRight;
      w_nextDown  = r_dirDown;
      w_nextX     = ball_x + 8'd1;
      w_nextY     = ball_y + 9'd1;
      if (r_dirRight) begin
         if (w_hit) begin
            w_nextRight = 1'b0;
            w_nextX     = ball_x - 8'd1;
         end
      end else if (w_x10 <= c_WALL_LIM) begin
         w_nextRight = 1'b1;
      end else begin
         w_nextX = ball_x - 8'd1;
      end
      if (r_dirDown) begin
         if (w_y10 + c_BALL >= c_BOTTOM) begin
            w_nextDown = 1'b0;
            w_nextY    = ball_y - 9'd1;
         end
      end else if (w_y10 > c_TOP_LIM) begin
         w_nextY = ball_y - 9'd1;
      end else begin
         w_nextDown = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         r_state      <= S_IDLE;
         r_tickCount  <= '0;
         r_serveCount <= '0;
         r_dirRight   <= 1'b1;
         r_dirDown    <= 1'b1;
         ball_x       <= c_SERVE_X;
         ball_y       <= c_SERVE_Y;
         score        <= 8'd0;
         missCount    <= 8'd0;
         tickStrobe   <= 1'b0;
      end else if (resetGame) begin
         r_state      <= S_IDLE;
         r_tickCount  <= '0;
         r_serveCount <= '0;
         r_dirRight   <= 1'b1;
         r_dirDown    <= 1'b1;
         ball_x       <= c_SERVE_X;
         ball_y       <= c_SERVE_Y;
         score        <= 8'd0;
         missCount    <= 8'd0;
         tickStrobe   <= 1'b0;
      end else begin
         r_tickCount <= w_tickCountNext;
         tickStrobe  <= enableGame && (w_tickCountNext == c_TICK_LAST);
         case (r_state)
            S_IDLE: begin
               if (enableGame) r_state <= S_SERVE;
            end
            S_SERVE: begin
               if (w_tick) begin
                  if (r_serveCount == c_SERVE_LAST) begin
                     r_serveCount <= '0;
                     r_dirRight   <= 1'b1;
                     r_dirDown    <= 1'b1;
                     r_state      <= S_MOVE;
                  end else begin
                     r_serveCount <= r_serveCount + 1'b1;
                  end
               end
            end
            S_MOVE: begin
               if (w_tick) begin
                  if (w_miss) begin
                     missCount <= missCount + 8'd1;
                     r_state   <= S_MISS;
                  end else begin
                     ball_x     <= w_nextX;
                     ball_y     <= w_nextY;
                     r_dirRight <= w_nextRight;
                     r_dirDown  <= w_nextDown;
                     if (w_hit) begin
                        if (w_scoreInc >= c_WIN) begin
                           score   <= c_WIN;
                           r_state <= S_WON;
                        end else begin
                           score <= w_scoreInc;
                        end
                     end
                  end
               end
            end
            S_MISS: begin
               if (w_tick) begin
                  if (r_serveCount == c_SERVE_LAST) begin
                     r_serveCount <= '0;
                     ball_x       <= c_SERVE_X;
                     ball_y       <= c_SERVE_Y;
                     r_state      <= S_SERVE;
                  end else begin
                     r_serveCount <= r_serveCount + 1'b1;
                  end
               end
            end
            S_WON: begin
               r_state <= S_WON;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ball_engine
//  Purpose  : Directed self-checking bench for ball_engine along a hand-traced
//             ball trajectory, plus a short-geometry instance for the win path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ball_engine;

   logic       clock = 1'b0;
   logic       resetApp, resetGame, enableGame;
   logic [8:0] paddleY;
   logic [7:0] ball_x, score, missCount;
   logic [8:0] ball_y;
   logic       tickStrobe;

   logic       winReset, winEnable;
   logic [8:0] winPaddle;
   logic [7:0] winX, winScore, winMiss;
   logic [8:0] winY;
   logic       winStrobe;

   int assertCount = 0;
   int failCount   = 0;
   bit sawStrobe;

   always #5 clock = ~clock;

   ball_engine #(.TICK_DIV(4), .SERVE_TICKS(2)) dut (
      .clock(clock), .resetApp(resetApp), .resetGame(resetGame),
      .enableGame(enableGame), .paddle_y(paddleY), .ball_x(ball_x),
      .ball_y(ball_y), .score(score), .missCount(missCount),
      .tickStrobe(tickStrobe)
   );

   // Serve point placed five pixels short of the paddle face so one hit wins.
   ball_engine #(.TICK_DIV(4), .SERVE_TICKS(2), .SERVE_X(205), .WIN_SCORE(1)) dutWin (
      .clock(clock), .resetApp(resetApp), .resetGame(winReset),
      .enableGame(winEnable), .paddle_y(winPaddle), .ball_x(winX),
      .ball_y(winY), .score(winScore), .missCount(winMiss),
      .tickStrobe(winStrobe)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Starts on a falling edge; returns on the falling edge after the n-th tick took effect.
   task automatic stepTicks(input int n, input bit onWin);
      for (int i = 0; i < n; i++) begin
         int guard;
         guard = 0;
         while ((onWin ? winStrobe : tickStrobe) !== 1'b1 && guard < 16) begin
            @(negedge clock);
            guard++;
         end
         assertCount++;
         assert (guard < 16) else begin
            failCount++;
            $error("FAIL tickTimeout: waited %0d cycles, required under 16", guard);
         end
         @(negedge clock);
      end
   endtask

   task automatic checkBall(input string tag, input int x, input int y);
      check({tag, "_x"}, 32'(ball_x), 32'(x));
      check({tag, "_y"}, 32'(ball_y), 32'(y));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetApp   = 1'b1;
      resetGame  = 1'b0;
      enableGame = 1'b0;
      paddleY    = 9'd130;
      winReset   = 1'b0;
      winEnable  = 1'b0;
      winPaddle  = 9'd85;
      repeat (3) @(negedge clock);
      checkBall("reset", 120, 80);
      check("resetScore", 32'(score), 0);
      check("resetMiss", 32'(missCount), 0);
      check("resetStrobe", 32'(tickStrobe), 0);
      resetApp = 1'b0;

      @(negedge clock);
      enableGame = 1'b1;
      repeat (2) @(negedge clock);
      check("strobeEarly", 32'(tickStrobe), 0);
      @(negedge clock);
      check("strobeFirst", 32'(tickStrobe), 1);
      repeat (3) @(negedge clock);
      check("strobeGap", 32'(tickStrobe), 0);
      @(negedge clock);
      check("strobePeriod", 32'(tickStrobe), 1);
      stepTicks(1, 0);
      checkBall("serveHeld", 120, 80);
      stepTicks(1, 0);
      checkBall("firstMove", 121, 81);

      enableGame = 1'b0;
      sawStrobe  = 1'b0;
      repeat (50) begin
         @(negedge clock);
         if (tickStrobe) sawStrobe = 1'b1;
      end
      check("pauseStrobe", 32'(sawStrobe), 0);
      checkBall("paused", 121, 81);
      enableGame = 1'b1;
      stepTicks(1, 0);
      checkBall("resumed", 122, 82);

      stepTicks(78, 0);
      checkBall("bottomReach", 200, 160);
      stepTicks(1, 0);
      checkBall("bottomBounce", 201, 159);
      stepTicks(9, 0);
      checkBall("atPaddle", 210, 150);
      check("scoreBeforeHit", 32'(score), 0);
      stepTicks(1, 0);
      checkBall("paddleHit", 209, 149);
      check("scoreHit", 32'(score), 1);
      paddleY = 9'd35;

      stepTicks(144, 0);
      checkBall("topReach", 65, 5);
      stepTicks(1, 0);
      checkBall("topBounce", 64, 6);
      stepTicks(56, 0);
      checkBall("wallReach", 8, 62);
      stepTicks(1, 0);
      checkBall("wallBounce", 9, 63);
      stepTicks(97, 0);
      checkBall("bottom2", 106, 160);
      stepTicks(1, 0);
      checkBall("bottom2Bounce", 107, 159);
      stepTicks(103, 0);
      checkBall("atPaddle2", 210, 56);
      stepTicks(1, 0);
      checkBall("paddleEdgeMiss", 211, 55);
      check("scoreNoHit", 32'(score), 1);
      stepTicks(23, 0);
      checkBall("missLine", 234, 32);
      check("missBefore", 32'(missCount), 0);
      stepTicks(1, 0);
      checkBall("missFrozen", 234, 32);
      check("missCount", 32'(missCount), 1);
      stepTicks(1, 0);
      checkBall("missHold", 234, 32);
      stepTicks(1, 0);
      checkBall("reServe", 120, 80);
      stepTicks(2, 0);
      checkBall("reServeHeld", 120, 80);
      stepTicks(1, 0);
      checkBall("reServeMove", 121, 81);

      resetGame = 1'b1;
      @(negedge clock);
      resetGame = 1'b0;
      checkBall("restart", 120, 80);
      check("restartScore", 32'(score), 0);
      check("restartMiss", 32'(missCount), 0);
      check("restartStrobe", 32'(tickStrobe), 0);
      repeat (2) @(negedge clock);
      check("restartGap", 32'(tickStrobe), 0);
      @(negedge clock);
      check("restartTick", 32'(tickStrobe), 1);
      paddleY = 9'd130;
      stepTicks(3, 0);
      checkBall("restartMove", 121, 81);
      stepTicks(89, 0);
      checkBall("atPaddle3", 210, 150);
      stepTicks(1, 0);
      check("scoreHit3", 32'(score), 1);

      #2;
      resetApp = 1'b1;
      #1;
      checkBall("asyncReset", 120, 80);
      check("asyncScore", 32'(score), 0);
      check("asyncStrobe", 32'(tickStrobe), 0);
      @(negedge clock);
      resetApp = 1'b0;
      @(negedge clock);
      checkBall("postReset", 120, 80);
      @(negedge clock);
      check("postResetGap", 32'(tickStrobe), 0);
      @(negedge clock);
      check("postResetTick", 32'(tickStrobe), 1);
      enableGame = 1'b0;

      winEnable = 1'b1;
      stepTicks(2, 1);
      check("winServe_x", 32'(winX), 205);
      stepTicks(5, 1);
      check("winAtPaddle_x", 32'(winX), 210);
      check("winAtPaddle_y", 32'(winY), 85);
      stepTicks(1, 1);
      check("winHit_x", 32'(winX), 209);
      check("winHit_y", 32'(winY), 86);
      check("winScore", 32'(winScore), 1);
      stepTicks(20, 1);
      check("wonFrozen_x", 32'(winX), 209);
      check("wonFrozen_y", 32'(winY), 86);
      check("wonScoreHeld", 32'(winScore), 1);
      check("wonMiss", 32'(winMiss), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
`default_nettype wire
